crc32_packet_gen: RTL and testbench

- Transmit-side CRC stage that sits directly upstream of the packet CRC checker.
- Accepts a packet as 32-bit words over a valid/ready stream.
- Forwards each payload word through a one-deep output register, accumulating CRC-32 as it goes.
- After the last payload word, emits one trailer word: the inverted CRC, flagged as the CRC word. The checker can then compare it against its own accumulated value.

---
 rtl/crc32_packet_gen.sv | 119 +++++++++++
 tb/tb_crc32_packet_gen.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc32_packet_gen.sv
// Transmit-side CRC-32 stage: forwards payload words through a one-deep output
// register and appends one inverted-CRC trailer word after each packet.
module crc32_packet_gen #(
    parameter int MAX_WORDS = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [31:0]      m_data,
    output logic             m_valid,
    output logic             m_crc,
    input  logic             m_ready,
    output logic             busy,
    output logic             len_err,
    output logic [CNT_W-1:0] pkt_count
);

    localparam int          WC_W = $clog2(MAX_WORDS) + 1;
    localparam logic [31:0] POLY = 32'hEDB88320;

    typedef enum logic {DATA, TRAIL} state_t;

    state_t          state;
    state_t          state_next;
    logic [31:0]     crc_reg;
    logic [31:0]     crc_next;
    logic [31:0]     crc_final;
    logic [WC_W-1:0] word_cnt;
    logic            free;
    logic            accept;
    logic            at_max;
    logic            load_trailer;

    // Reflected CRC-32 over one word, low byte first, fully unrolled in one cycle.
    function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] word);
        logic [31:0] c;
        c = crc ^ word;
        for (int i = 0; i < 32; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        return c;
    endfunction

    assign free         = !m_valid || m_ready;
    assign accept       = (state == DATA) && s_valid && free;
    assign load_trailer = (state == TRAIL) && free;
    assign at_max       = (word_cnt == WC_W'(MAX_WORDS - 1));
    assign crc_next     = crc32_word(crc_reg, s_data);
    assign crc_final    = crc_reg ^ 32'hFFFFFFFF;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next = state;
        s_ready    = 1'b0;
        case (state)
            DATA: begin
                s_ready = free;
                if (accept && (s_last || at_max)) begin
                    state_next = TRAIL;
                end
            end
            TRAIL: begin
                if (free) begin
                    state_next = DATA;
                end
            end
            default: state_next = DATA;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= DATA;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_reg   <= 32'hFFFFFFFF;
            word_cnt  <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_crc     <= 1'b0;
            busy      <= 1'b0;
            len_err   <= 1'b0;
            pkt_count <= '0;
        end else if (accept) begin
            m_data   <= s_data;
            m_valid  <= 1'b1;
            m_crc    <= 1'b0;
            crc_reg  <= crc_next;
            word_cnt <= word_cnt + WC_W'(1);
            busy     <= 1'b1;
            if (at_max && !s_last) begin
                len_err <= 1'b1;
            end
        end else if (load_trailer) begin
            // Trailer is the complement of the final-XORed CRC-32.
            m_data    <= ~crc_final;
            m_valid   <= 1'b1;
            m_crc     <= 1'b1;
            crc_reg   <= 32'hFFFFFFFF;
            word_cnt  <= '0;
            busy      <= 1'b0;
            pkt_count <= pkt_count + CNT_W'(1);
        end else if (free) begin
            m_valid <= 1'b0;
            m_crc   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_crc32_packet_gen.sv
// Directed self-checking bench for crc32_packet_gen, built with MAX_WORDS=4 so
// the forced-termination path is reachable with short packets.
module tb_crc32_packet_gen;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic [31:0]      m_data;
    logic             m_valid;
    logic             m_crc;
    logic             m_ready;
    logic             busy;
    logic             len_err;
    logic [CNT_W-1:0] pkt_count;

    int passed = 0;
    int total  = 0;

    crc32_packet_gen #(.MAX_WORDS(4), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_crc     (m_crc),
        .m_ready   (m_ready),
        .busy      (busy),
        .len_err   (len_err),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    // Reference per-word CRC-32 update (reflected, poly EDB88320).
    function automatic logic [31:0] crc_upd(input logic [31:0] crc, input logic [31:0] word);
        logic [31:0] c;
        c = crc ^ word;
        for (int i = 0; i < 32; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        #2;
        total++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid); else passed++;
        total++; if (m_crc !== 1'b0) $display("FAIL reset_m_crc: got %b want 0", m_crc); else passed++;
        total++; if (m_data !== 32'h0) $display("FAIL reset_m_data: got %h want 00000000", m_data); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (len_err !== 1'b0) $display("FAIL reset_len_err: got %b want 0", len_err); else passed++;
        total++; if (pkt_count !== '0) $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); else passed++;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // One-word packet with s_last, m_ready high throughout.
    task automatic test_single_word(input string name, input logic [31:0] w,
                                    input logic [31:0] exp_trailer, input logic [CNT_W-1:0] exp_cnt);
        s_data = w; s_valid = 1'b1; s_last = 1'b1; m_ready = 1'b1;
        #1;
        total++; if (s_ready !== 1'b1) $display("FAIL %s_s_ready_idle: got %b want 1", name, s_ready); else passed++;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        #1;
        total++; if ({m_valid, m_crc, m_data} !== {1'b1, 1'b0, w})
            $display("FAIL %s_payload: got v=%b crc=%b data=%h want v=1 crc=0 data=%h", name, m_valid, m_crc, m_data, w);
        else passed++;
        total++; if (busy !== 1'b1) $display("FAIL %s_busy_set: got %b want 1", name, busy); else passed++;
        total++; if (s_ready !== 1'b0) $display("FAIL %s_s_ready_trail: got %b want 0", name, s_ready); else passed++;
        tick();
        total++; if ({m_valid, m_crc, m_data} !== {1'b1, 1'b1, exp_trailer})
            $display("FAIL %s_trailer: got v=%b crc=%b data=%h want v=1 crc=1 data=%h", name, m_valid, m_crc, m_data, exp_trailer);
        else passed++;
        total++; if (pkt_count !== exp_cnt) $display("FAIL %s_pkt_count: got %0d want %0d", name, pkt_count, exp_cnt); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL %s_busy_clear: got %b want 0", name, busy); else passed++;
        tick();
        total++; if (m_valid !== 1'b0) $display("FAIL %s_m_valid_drop: got %b want 0", name, m_valid); else passed++;
    endtask

    // Three identical 3-word packets with s_valid held high and m_ready=1.
    task automatic test_back_to_back();
        logic [31:0] w[3];
        logic [32:0] exp_q[$];
        logic [32:0] got_q[$];
        logic [31:0] trailer;
        int idx, stalls, bad_stalls;
        logic prev_last;
        w[0] = 32'h12345678; w[1] = 32'hDEADBEEF; w[2] = 32'h0BADF00D;
        trailer = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) trailer = crc_upd(trailer, w[i]);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, w[i]});
            exp_q.push_back({1'b1, trailer});
        end
        idx = 0; stalls = 0; bad_stalls = 0; prev_last = 1'b0;
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            s_valid = (idx < 9);
            s_data  = w[idx % 3];
            s_last  = ((idx % 3) == 2);
            #1;
            if (s_valid) begin
                if (s_ready) begin
                    prev_last = s_last;
                    idx++;
                end else begin
                    stalls++;
                    if (!prev_last) bad_stalls++;
                    prev_last = 1'b0;
                end
            end
            tick();
            if (m_valid) got_q.push_back({m_crc, m_data});
        end
        s_valid = 1'b0; s_last = 1'b0;
        total++; if (idx !== 9) $display("FAIL b2b_accepted: got %0d words want 9", idx); else passed++;
        total++; if (stalls !== 2) $display("FAIL b2b_stall_count: got %0d want 2", stalls); else passed++;
        total++; if (bad_stalls !== 0) $display("FAIL b2b_stall_position: got %0d misplaced want 0", bad_stalls); else passed++;
        total++; if (got_q.size() !== 12) $display("FAIL b2b_out_count: got %0d want 12", got_q.size()); else passed++;
        for (int i = 0; i < 12; i++) begin
            if (i < got_q.size()) begin
                total++; if (got_q[i] !== exp_q[i])
                    $display("FAIL b2b_out_%0d: got crc=%b data=%h want crc=%b data=%h", i, got_q[i][32], got_q[i][31:0], exp_q[i][32], exp_q[i][31:0]);
                else passed++;
            end
        end
        total++; if (pkt_count !== CNT_W'(5)) $display("FAIL b2b_pkt_count: got %0d want 5", pkt_count); else passed++;
    endtask

    task automatic test_backpressure();
        logic [31:0] w1, w2, w3, trailer;
        w1 = 32'hA5A5A5A5; w2 = 32'h00000001; w3 = 32'hCAFEF00D;
        trailer = crc_upd(crc_upd(crc_upd(32'hFFFFFFFF, w1), w2), w3);
        s_data = w1; s_valid = 1'b1; s_last = 1'b0; m_ready = 1'b1;
        tick();
        m_ready = 1'b0; s_data = w2;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (s_ready !== 1'b0) $display("FAIL bp_s_ready_%0d: got %b want 0", i, s_ready); else passed++;
            tick();
            total++; if ({m_valid, m_crc, m_data} !== {1'b1, 1'b0, w1})
                $display("FAIL bp_hold_%0d: got v=%b crc=%b data=%h want v=1 crc=0 data=%h", i, m_valid, m_crc, m_data, w1);
            else passed++;
        end
        m_ready = 1'b1;
        #1;
        total++; if (s_ready !== 1'b1) $display("FAIL bp_s_ready_resume: got %b want 1", s_ready); else passed++;
        tick();
        total++; if (m_data !== w2) $display("FAIL bp_word2: got %h want %h", m_data, w2); else passed++;
        s_data = w3; s_last = 1'b1;
        tick();
        total++; if (m_data !== w3) $display("FAIL bp_word3: got %h want %h", m_data, w3); else passed++;
        s_valid = 1'b0; s_last = 1'b0;
        tick();
        total++; if ({m_crc, m_data} !== {1'b1, trailer})
            $display("FAIL bp_trailer: got crc=%b data=%h want crc=1 data=%h", m_crc, m_data, trailer);
        else passed++;
        total++; if (pkt_count !== CNT_W'(6)) $display("FAIL bp_pkt_count: got %0d want 6", pkt_count); else passed++;
    endtask

    // Six words without s_last into a MAX_WORDS=4 instance.
    task automatic test_max_words();
        logic [31:0] w[7];
        logic [31:0] t1, t2;
        w[0] = 32'h11111111; w[1] = 32'h22222222; w[2] = 32'h33333333; w[3] = 32'h44444444;
        w[4] = 32'h55555555; w[5] = 32'h66666666; w[6] = 32'h77777777;
        t1 = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) t1 = crc_upd(t1, w[i]);
        t2 = 32'hFFFFFFFF;
        for (int i = 4; i < 7; i++) t2 = crc_upd(t2, w[i]);
        m_ready = 1'b1; s_last = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = w[i];
            #1;
            total++; if (s_ready !== 1'b1) $display("FAIL max_s_ready_%0d: got %b want 1", i, s_ready); else passed++;
            tick();
            total++; if (m_data !== w[i]) $display("FAIL max_word_%0d: got %h want %h", i, m_data, w[i]); else passed++;
            if (i == 2) begin
                total++; if (len_err !== 1'b0) $display("FAIL max_len_err_early: got %b want 0", len_err); else passed++;
            end
        end
        total++; if (len_err !== 1'b1) $display("FAIL max_len_err_set: got %b want 1", len_err); else passed++;
        s_data = w[4];
        #1;
        total++; if (s_ready !== 1'b0) $display("FAIL max_s_ready_trail: got %b want 0", s_ready); else passed++;
        tick();
        total++; if ({m_crc, m_data} !== {1'b1, t1})
            $display("FAIL max_trailer: got crc=%b data=%h want crc=1 data=%h", m_crc, m_data, t1);
        else passed++;
        total++; if (busy !== 1'b0) $display("FAIL max_busy_clear: got %b want 0", busy); else passed++;
        for (int i = 4; i < 6; i++) begin
            s_data = w[i];
            tick();
            total++; if ({m_crc, m_data} !== {1'b0, w[i]})
                $display("FAIL max_new_word_%0d: got crc=%b data=%h want crc=0 data=%h", i, m_crc, m_data, w[i]);
            else passed++;
        end
        total++; if (busy !== 1'b1) $display("FAIL max_busy_again: got %b want 1", busy); else passed++;
        s_data = w[6]; s_last = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        tick();
        total++; if ({m_crc, m_data} !== {1'b1, t2})
            $display("FAIL max_second_trailer: got crc=%b data=%h want crc=1 data=%h", m_crc, m_data, t2);
        else passed++;
        total++; if (len_err !== 1'b1) $display("FAIL max_len_err_sticky: got %b want 1", len_err); else passed++;
        total++; if (pkt_count !== CNT_W'(8)) $display("FAIL max_pkt_count: got %0d want 8", pkt_count); else passed++;
    endtask

    task automatic test_reset_mid_packet();
        m_ready = 1'b1; s_last = 1'b0; s_valid = 1'b1;
        s_data = 32'h89ABCDEF;
        tick();
        s_data = 32'h01234567;
        tick();
        s_valid = 1'b0;
        reset = 1'b1;
        #1;
        total++; if ({m_valid, m_crc, m_data} !== {1'b0, 1'b0, 32'h0})
            $display("FAIL rst_mid_outputs: got v=%b crc=%b data=%h want v=0 crc=0 data=00000000", m_valid, m_crc, m_data);
        else passed++;
        total++; if ({busy, len_err} !== 2'b00) $display("FAIL rst_mid_flags: got busy=%b len_err=%b want 0 0", busy, len_err); else passed++;
        total++; if (pkt_count !== '0) $display("FAIL rst_mid_pkt_count: got %0d want 0", pkt_count); else passed++;
        tick();
        reset = 1'b0;
        tick();
        test_single_word("rst_zero", 32'h00000000, 32'hDEBB20E3, CNT_W'(1));
    endtask

    initial begin
        test_reset();
        test_single_word("single_zero", 32'h00000000, 32'hDEBB20E3, CNT_W'(1));
        test_single_word("single_ones", 32'hFFFFFFFF, 32'h00000000, CNT_W'(2));
        test_back_to_back();
        test_backpressure();
        test_max_words();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
